mem_stage: RTL

//  MEM stage of the 5-stage MIPS pipeline, between EX and WB. Accepts EX results plus the exception bus.

---
 rtl/mem_stage.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: waits for data-SRAM load responses, aligns load data,
// and hands results to WB. load_op: 0 none, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lw, 6 lwl, 7 lwr.
module mem_stage #(
    parameter int unsigned ES_TO_MS_BUS_WD = 112,
    parameter int unsigned MS_TO_WS_BUS_WD = 73,
    parameter int unsigned MS_EX_BUS_WD    = 12
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic [MS_EX_BUS_WD-1:0]    es_ex_bus,
    output logic                       ms_allowin,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_EX_BUS_WD-1:0]    ms_ex_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       flush,
    output logic                       ms_write_reg,
    output logic [4:0]                 ms_reg_dest,
    output logic                       ms_fwd_ok,
    output logic [31:0]                ms_fwd_data
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_LWL = 4'd6;
    localparam logic [3:0] OP_LWR = 4'd7;

    logic                       ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] bus_r;
    logic [MS_EX_BUS_WD-1:0]    ex_bus_r;
    logic                       data_buf_valid;
    logic [31:0]                data_buf;
    logic [1:0]                 cancel_cnt;
    logic [1:0]                 cancel_cnt_next;

    logic [3:0]  load_op;
    logic        mem_req;
    logic [1:0]  addr_lo;
    logic [31:0] rt_value;
    logic [3:0]  gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;

    assign {load_op, mem_req, addr_lo, rt_value, gr_we, dest, alu_result, pc} = bus_r;

    logic resp_drop;
    logic resp_live;
    logic data_ready;
    logic ms_ready_go;
    logic ms_leave;
    logic buf_capture;
    logic cancel_inc;

    // A response while cancel_cnt != 0 belongs to an already-flushed load.
    assign resp_drop   = data_sram_data_ok && (cancel_cnt != 2'd0);
    assign resp_live   = data_sram_data_ok && (cancel_cnt == 2'd0);
    assign data_ready  = !mem_req || data_buf_valid || resp_live;
    assign ms_ready_go = data_ready;
    assign ms_allowin  = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;
    assign ms_leave    = ms_to_ws_valid && ws_allowin;
    assign buf_capture = resp_live && ms_valid && mem_req && !data_buf_valid;
    assign cancel_inc  = flush && ms_valid && mem_req && !data_buf_valid && !resp_live;

    always_comb begin
        cancel_cnt_next = cancel_cnt;
        if (cancel_inc && !resp_drop) begin
            if (cancel_cnt != 2'd3) begin
                cancel_cnt_next = cancel_cnt + 2'd1;
            end
        end else if (resp_drop && !cancel_inc) begin
            cancel_cnt_next = cancel_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid       <= 1'b0;
            data_buf_valid <= 1'b0;
            cancel_cnt     <= 2'd0;
        end else begin
            if (flush) begin
                ms_valid <= 1'b0;
            end else if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
            end
            if (flush || ms_leave) begin
                data_buf_valid <= 1'b0;
            end else if (buf_capture) begin
                data_buf_valid <= 1'b1;
            end
            cancel_cnt <= cancel_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (es_to_ms_valid && ms_allowin) begin
            bus_r    <= es_to_ms_bus;
            ex_bus_r <= es_ex_bus;
        end
        if (buf_capture) begin
            data_buf <= data_sram_rdata;
        end
    end

    logic [31:0] rdata_sel;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [4:0]  lwl_shamt;
    logic [4:0]  lwr_shamt;
    logic [31:0] lwl_data;
    logic [31:0] lwr_data;
    logic [31:0] final_result;
    logic [3:0]  final_gr_we;

    assign rdata_sel = data_buf_valid ? data_buf : data_sram_rdata;

    always_comb begin
        load_byte = rdata_sel[{addr_lo, 3'b000} +: 8];
        load_half = addr_lo[1] ? rdata_sel[31:16] : rdata_sel[15:0];
        lwl_shamt = {~addr_lo, 3'b000};
        lwr_shamt = {addr_lo, 3'b000};
        lwl_data  = (rdata_sel << lwl_shamt) | (rt_value & ~(32'hffff_ffff << lwl_shamt));
        lwr_data  = (rdata_sel >> lwr_shamt) | (rt_value & ~(32'hffff_ffff >> lwr_shamt));
        final_result = alu_result;
        final_gr_we  = gr_we;
        case (load_op)
            OP_LB:   final_result = {{24{load_byte[7]}}, load_byte};
            OP_LBU:  final_result = {24'd0, load_byte};
            OP_LH:   final_result = {{16{load_half[15]}}, load_half};
            OP_LHU:  final_result = {16'd0, load_half};
            OP_LW:   final_result = rdata_sel;
            OP_LWL: begin
                final_result = lwl_data;
                final_gr_we  = 4'b1111 << ~addr_lo;
            end
            OP_LWR: begin
                final_result = lwr_data;
                final_gr_we  = 4'b1111 >> addr_lo;
            end
            default: ;
        endcase
    end

    assign ms_to_ws_bus = {final_gr_we, dest, final_result, pc};
    assign ms_ex_bus    = ms_valid ? ex_bus_r : '0;
    assign ms_write_reg = ms_valid && (gr_we != 4'd0);
    assign ms_reg_dest  = ms_valid ? dest : 5'd0;
    assign ms_fwd_ok    = ms_write_reg && data_ready;
    assign ms_fwd_data  = final_result;

endmodule
